// File: rtl/twiddle_seq.sv
// Radix-2 DIF twiddle sequencer: walks stages and butterflies of an N-point
// FFT and streams ROM twiddles (optionally conjugated) over a valid/ready port.
module twiddle_seq #(
    parameter int NMAX = 128,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    log2n,
    input  logic          inverse,
    output logic          tw_valid,
    input  logic          tw_ready,
    output logic [DW-1:0] tw_re,
    output logic [DW-1:0] tw_im,
    output logic [2:0]    tw_stage,
    output logic          tw_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int         LOGN  = $clog2(NMAX);
    localparam int         JW    = (LOGN > 1) ? LOGN - 1 : 1;
    localparam int         HALF  = NMAX / 2;
    localparam logic [2:0] LOGN3 = 3'(LOGN);
    localparam real        PI    = 3.14159265358979323846;
    localparam real        SCALE = 2.0 ** (DW - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic signed [DW-1:0] sat_round(input real x);
        longint v;
        longint lim;
        lim = longint'(1) << (DW - 1);
        if (x >= 0.0) v = longint'($rtoi(x + 0.5));
        else          v = -longint'($rtoi(0.5 - x));
        if (v > lim - 1) v = lim - 1;
        else if (v < -lim) v = -lim;
        return v[DW-1:0];
    endfunction

    logic signed [DW-1:0] rom_re [HALF];
    logic signed [DW-1:0] rom_im [HALF];

    for (genvar m = 0; m < HALF; m++) begin : g_rom
        localparam real ANG = 2.0 * PI * m / NMAX;
        assign rom_re[m] = sat_round(SCALE * $cos(ANG));
        assign rom_im[m] = sat_round(-(SCALE * $sin(ANG)));
    end

    state_t        state_q, state_d;
    logic [2:0]    ln_q;
    logic          inv_q;
    logic [2:0]    s_q;
    logic [JW-1:0] j_q;
    logic          err_q;

    logic          legal, accept, fire;
    logic          j_end, s_end, last;
    logic [2:0]    shamt;
    logic [JW-1:0] j_max, j_mask, idx;
    logic signed [DW-1:0] re_w, im_w, im_neg;

    assign legal  = (log2n != 3'd0) && (log2n <= LOGN3);
    assign accept = (state_q == IDLE) && start && legal;
    assign fire   = tw_valid && tw_ready;

    // One shift serves both the mod mask (N>>(s+1)) and the ROM stride.
    always_comb begin
        shamt  = LOGN3 - ln_q + s_q;
        j_max  = {JW{1'b1}} >> (LOGN3 - ln_q);
        j_mask = {JW{1'b1}} >> shamt;
        idx    = (j_q & j_mask) << shamt;
        j_end  = (j_q == j_max);
        s_end  = (s_q == ln_q - 3'd1);
        last   = j_end && s_end;
        re_w   = rom_re[idx];
        im_w   = rom_im[idx];
        if (im_w == {1'b1, {(DW-1){1'b0}}}) im_neg = {1'b0, {(DW-1){1'b1}}};
        else                                im_neg = -im_w;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (fire && last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ln_q    <= 3'd0;
            inv_q   <= 1'b0;
            s_q     <= 3'd0;
            j_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && start && !legal;
            if (accept) begin
                ln_q  <= log2n;
                inv_q <= inverse;
                s_q   <= 3'd0;
                j_q   <= '0;
            end else if (fire) begin
                if (j_end) begin
                    j_q <= '0;
                    s_q <= last ? 3'd0 : s_q + 3'd1;
                end else begin
                    j_q <= j_q + JW'(1);
                end
            end
        end
    end

    always_comb begin
        tw_valid = (state_q == RUN);
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        err      = err_q;
        tw_re    = '0;
        tw_im    = '0;
        tw_stage = 3'd0;
        tw_last  = 1'b0;
        if (tw_valid) begin
            tw_re    = re_w;
            tw_im    = inv_q ? im_neg : im_w;
            tw_stage = s_q;
            tw_last  = last;
        end
    end

endmodule

// File: tb/tb_twiddle_seq.sv
// Bench for twiddle_seq: trig-based reference model, random back-pressure,
// mid-run start noise, illegal sizes and mid-sequence reset.
module tb_twiddle_seq;

    localparam int  NMAX = 128;
    localparam int  DW   = 16;
    localparam real PI   = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    log2n;
    logic          inverse;
    logic          tw_valid;
    logic          tw_ready;
    logic [DW-1:0] tw_re;
    logic [DW-1:0] tw_im;
    logic [2:0]    tw_stage;
    logic          tw_last;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;
    int got_re[$];
    int got_im[$];
    int got_st[$];
    int got_last[$];

    int n4_re[4] = '{32767, 0, 32767, 32767};
    int n4_im[4] = '{0, -32768, 0, 0};
    int n4_st[4] = '{0, 0, 1, 1};
    int n4_ls[4] = '{0, 0, 0, 1};
    int n8_re[4] = '{32767, 23170, 0, -23170};
    int n8_im[4] = '{0, 23170, 32767, 23170};

    always #5 clk = ~clk;

    twiddle_seq #(.NMAX(NMAX), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .log2n(log2n),
        .inverse(inverse), .tw_valid(tw_valid), .tw_ready(tw_ready),
        .tw_re(tw_re), .tw_im(tw_im), .tw_stage(tw_stage),
        .tw_last(tw_last), .busy(busy), .done(done), .err(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int rnd(input real x);
        return $rtoi($floor(x + 0.5));
    endfunction

    // Twiddle straight from the FFT definition: W_N^k, k from DIF indexing.
    task automatic ref_tw(input int ln, input int s, input int j, input bit inv,
                          output int re, output int im);
        int  n, half, k, m;
        real a;
        n    = 1 << ln;
        half = n >> (s + 1);
        k    = (j % half) << s;
        m    = k * (NMAX / n);
        a    = 2.0 * PI * m / NMAX;
        re   = sat(rnd(32768.0 * $cos(a)));
        im   = sat(-rnd(32768.0 * $sin(a)));
        if (inv) im = sat(-im);
    endtask

    task automatic run_seq(input int ln, input bit inv, input int pct,
                           input int stall_at, input int stall_len,
                           input int abort_at);
        int n, hs, wait_c, er, ei;
        bit el, rdy;
        got_re.delete();
        got_im.delete();
        got_st.delete();
        got_last.delete();
        n        = 1 << ln;
        hs       = 0;
        start    = 1'b1;
        log2n    = 3'(ln);
        inverse  = inv;
        tw_ready = 1'b0;
        tick;
        chk("err_legal", 32'(err), 0);
        for (int s = 0; s < ln; s++) begin
            for (int j = 0; j < n / 2; j++) begin
                ref_tw(ln, s, j, inv, er, ei);
                el     = (s == ln - 1) && (j == n / 2 - 1);
                wait_c = 0;
                do begin
                    if (hs == stall_at && wait_c < stall_len) rdy = 1'b0;
                    else if (pct > 0 && $urandom_range(99) < pct) rdy = 1'b0;
                    else rdy = 1'b1;
                    if (wait_c >= 20) rdy = 1'b1;
                    tw_ready = rdy;
                    start    = ($urandom_range(7) == 0);
                    log2n    = 3'($urandom_range(7));
                    inverse  = 1'($urandom_range(1));
                    chk("valid", 32'(tw_valid), 1);
                    chk("busy", 32'(busy), 1);
                    chk("re", 32'($signed(tw_re)), er);
                    chk("im", 32'($signed(tw_im)), ei);
                    chk("stage", 32'(tw_stage), s);
                    chk("last", 32'(tw_last), 32'(el));
                    if (rdy) begin
                        got_re.push_back(int'($signed(tw_re)));
                        got_im.push_back(int'($signed(tw_im)));
                        got_st.push_back(int'(tw_stage));
                        got_last.push_back(int'(tw_last));
                    end
                    tick;
                    wait_c++;
                end while (!rdy);
                hs++;
                if (hs == abort_at) begin
                    start    = 1'b0;
                    tw_ready = 1'b0;
                    rst_n    = 1'b0;
                    tick;
                    chk("rst_valid", 32'(tw_valid), 0);
                    chk("rst_busy", 32'(busy), 0);
                    chk("rst_re", 32'($signed(tw_re)), 0);
                    chk("rst_stage", 32'(tw_stage), 0);
                    rst_n = 1'b1;
                    tick;
                    chk("post_rst_valid", 32'(tw_valid), 0);
                    return;
                end
            end
        end
        start    = 1'b0;
        tw_ready = 1'b0;
        chk("done", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_valid", 32'(tw_valid), 0);
        tick;
        chk("done_pulse", 32'(done), 0);
        chk("idle_valid", 32'(tw_valid), 0);
    endtask

    initial begin
        int lsum;
        rst_n    = 1'b0;
        start    = 1'b1;
        log2n    = 3'd2;
        inverse  = 1'b0;
        tw_ready = 1'b1;
        repeat (3) tick;
        chk("rst_valid0", 32'(tw_valid), 0);
        chk("rst_re0", 32'($signed(tw_re)), 0);
        chk("rst_im0", 32'($signed(tw_im)), 0);
        chk("rst_stage0", 32'(tw_stage), 0);
        chk("rst_last0", 32'(tw_last), 0);
        chk("rst_busy0", 32'(busy), 0);
        chk("rst_done0", 32'(done), 0);
        chk("rst_err0", 32'(err), 0);
        rst_n = 1'b1;
        start = 1'b0;
        tick;
        chk("idle_after_rst", 32'(tw_valid), 0);

        run_seq(2, 1'b0, 0, -1, 0, -1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("n4_re%0d", i), got_re[i], n4_re[i]);
            chk($sformatf("n4_im%0d", i), got_im[i], n4_im[i]);
            chk($sformatf("n4_st%0d", i), got_st[i], n4_st[i]);
            chk($sformatf("n4_last%0d", i), got_last[i], n4_ls[i]);
        end

        run_seq(2, 1'b0, 0, 1, 3, -1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_re%0d", i), got_re[i], n4_re[i]);
            chk($sformatf("stall_im%0d", i), got_im[i], n4_im[i]);
        end

        run_seq(3, 1'b1, 30, -1, 0, -1);
        chk("n8_count", got_re.size(), 12);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("n8i_re%0d", i), got_re[i], n8_re[i]);
            chk($sformatf("n8i_im%0d", i), got_im[i], n8_im[i]);
            chk($sformatf("n8i_st%0d", i), got_st[i], 0);
        end

        start = 1'b1;
        log2n = 3'd0;
        tick;
        start = 1'b0;
        chk("err_pulse", 32'(err), 1);
        chk("err_valid", 32'(tw_valid), 0);
        chk("err_busy", 32'(busy), 0);
        tick;
        chk("err_clear", 32'(err), 0);
        chk("err_valid2", 32'(tw_valid), 0);

        for (int r = 0; r < 10; r++)
            run_seq($urandom_range(1, 7), 1'($urandom_range(1)),
                    $urandom_range(0, 40), -1, 0, -1);

        run_seq(7, 1'b0, 20, -1, 0, 100);
        run_seq(7, 1'b0, 0, -1, 0, -1);
        chk("n128_count", got_re.size(), 448);
        chk("n128_first_re", got_re[0], 32767);
        chk("n128_first_im", got_im[0], 0);
        chk("n128_first_st", got_st[0], 0);
        lsum = 0;
        foreach (got_last[i]) lsum += got_last[i];
        chk("n128_last_once", lsum, 1);
        chk("n128_last_pos", got_last[447], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
